mux_tg_bbm: RTL and testbench

//  Parametrised N-channel, WIDTH-bit bus multiplexer built from per-channel transmission-gate cells.

---
 rtl/mux_tg_pkg.sv | 19 +
 rtl/tg_cell_w.sv | 12 +
 rtl/mux_tg_bbm.sv | 117 +++++++++++
 tb/tb_mux_tg_bbm.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mux_tg_pkg.sv
// Shared types for the break-before-make transmission-gate bus mux.
// Select-to-gate decode helper used by the control FSM.
package mux_tg_pkg;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_GUARD = 2'd1,
        S_ON    = 2'd2
    } state_e;

    // Returns a one-hot gate vector for sel, or all-zero when sel is out of range.
    function automatic logic [31:0] onehot(input int unsigned sel, input int unsigned nch);
        onehot = '0;
        if (sel < nch) begin
            onehot = 32'd1 << sel;
        end
    endfunction

endpackage

// File: rtl/tg_cell_w.sv
// WIDTH-bit transmission-gate cell: passes a onto out when ctrl is high, otherwise releases the bus.
module tg_cell_w #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             ctrl,
    input  logic [WIDTH-1:0] a,
    output wire  [WIDTH-1:0] out
);

    assign out = ctrl ? a : 'z;

endmodule

// File: rtl/mux_tg_bbm.sv
// N-channel tri-state bus mux with registered select and a GUARD-cycle all-off gap between drivers.
// Gate latency 1 cycle after a select transfer; sel_ready is low while the guard gap runs.
module mux_tg_bbm
    import mux_tg_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned NCH   = 4,
    parameter  int unsigned GUARD = 1,
    localparam int unsigned SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] din,
    input  logic                 en,
    input  logic [SELW-1:0]      sel,
    input  logic                 sel_valid,
    output logic                 sel_ready,
    output logic [NCH-1:0]       tg_ctrl,
    output logic [SELW-1:0]      cur_sel,
    output logic                 busy,
    output logic                 sel_err,
    output wire  [WIDTH-1:0]     y_out
);

    localparam int unsigned CW = $clog2(GUARD + 1);

    state_e          state_q, state_d;
    logic [SELW-1:0] cur_sel_q, cur_sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sel_err_q, sel_err_d;
    logic            xfer;
    logic            sel_ok;

    assign sel_ready = (state_q != S_GUARD) & rst_n;
    assign xfer      = sel_valid & sel_ready;
    assign sel_ok    = 32'(sel) < NCH;

    // en wins over any same-cycle transfer, so errors are only flagged while enabled.
    always_comb begin
        state_d   = state_q;
        cur_sel_d = cur_sel_q;
        cnt_d     = cnt_q;
        sel_err_d = 1'b0;
        if (!en) begin
            state_d = S_OFF;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (xfer) begin
                        if (sel_ok) begin
                            state_d   = S_ON;
                            cur_sel_d = sel;
                        end else begin
                            sel_err_d = 1'b1;
                        end
                    end
                end
                S_ON: begin
                    if (xfer) begin
                        if (!sel_ok) begin
                            sel_err_d = 1'b1;
                        end else if (sel != cur_sel_q) begin
                            state_d   = S_GUARD;
                            cur_sel_d = sel;
                            cnt_d     = CW'(GUARD - 1);
                        end
                    end
                end
                S_GUARD: begin
                    if (cnt_q == '0) begin
                        state_d = S_ON;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_OFF;
            cur_sel_q <= '0;
            cnt_q     <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_sel_q <= cur_sel_d;
            cnt_q     <= cnt_d;
            sel_err_q <= sel_err_d;
        end
    end

    always_comb begin
        tg_ctrl = '0;
        if (state_q == S_ON) begin
            tg_ctrl = NCH'(onehot(32'(cur_sel_q), NCH));
        end
    end

    assign cur_sel = cur_sel_q;
    assign busy    = (state_q == S_GUARD);
    assign sel_err = sel_err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_cell
        tg_cell_w #(.WIDTH(WIDTH)) u_cell (
            .ctrl (tg_ctrl[i]),
            .a    (din[i*WIDTH +: WIDTH]),
            .out  (y_out)
        );
    end

    a_onehot_gates: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(tg_ctrl));

endmodule

// File: tb/tb_mux_tg_bbm.sv
module tb_mux_tg_bbm;

    localparam int WIDTH = 8;
    localparam int NCH   = 3;
    localparam int GUARD = 2;
    localparam int SELW  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH*WIDTH-1:0] din;
    logic                 en;
    logic [SELW-1:0]      sel;
    logic                 sel_valid;
    logic                 sel_ready;
    logic [NCH-1:0]       tg_ctrl;
    logic [SELW-1:0]      cur_sel;
    logic                 busy;
    logic                 sel_err;
    wire  [WIDTH-1:0]     y_out;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Reference: which channel drives the bus (-1 = none), remaining all-off cycles, latched select.
    int m_drv = -1;
    int m_gap = 0;
    int m_cur = 0;
    bit m_err = 1'b0;

    always #5 clk = ~clk;

    mux_tg_bbm #(.WIDTH(WIDTH), .NCH(NCH), .GUARD(GUARD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .en        (en),
        .sel       (sel),
        .sel_valid (sel_valid),
        .sel_ready (sel_ready),
        .tg_ctrl   (tg_ctrl),
        .cur_sel   (cur_sel),
        .busy      (busy),
        .sel_err   (sel_err),
        .y_out     (y_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        m_err = 1'b0;
        if (!rst_n) begin
            m_drv = -1;
            m_gap = 0;
            m_cur = 0;
        end else if (!en) begin
            m_drv = -1;
            m_gap = 0;
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_drv = m_cur;
        end else if (sel_valid) begin
            if (int'(sel) >= NCH) begin
                m_err = 1'b1;
            end else if (m_drv < 0) begin
                m_drv = int'(sel);
                m_cur = m_drv;
            end else if (int'(sel) != m_drv) begin
                m_drv = -1;
                m_gap = GUARD;
                m_cur = int'(sel);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            logic [NCH-1:0] exp_tg;
            exp_tg = '0;
            if (m_drv >= 0) exp_tg[m_drv] = 1'b1;
            chk("cyc_tg_ctrl", 32'(tg_ctrl), 32'(exp_tg));
            chk("cyc_busy", 32'(busy), 32'(m_gap > 0));
            chk("cyc_cur_sel", 32'(cur_sel), 32'(m_cur));
            chk("cyc_sel_err", 32'(sel_err), 32'(m_err));
            chk("cyc_sel_ready", 32'(sel_ready), 32'((m_gap == 0) && rst_n));
            chk("cyc_onehot0", 32'($onehot0(tg_ctrl)), 32'd1);
            if (m_drv >= 0) chk("cyc_y_out", 32'(y_out), 32'(din[m_drv*WIDTH +: WIDTH]));
        end
    end

    initial begin
        rst_n     = 1'b0;
        en        = 1'b0;
        sel_valid = 1'b0;
        sel       = '0;
        din       = {8'hA5, 8'h77, 8'h3C};

        step();
        cmp_en = 1'b1;
        step();
        chk("rst_tg_ctrl", 32'(tg_ctrl), 32'd0);
        chk("rst_cur_sel", 32'(cur_sel), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_ready_low", 32'(sel_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(sel_ready), 32'd1);

        en = 1'b1; sel = 2'd2; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        chk("start_tg", 32'(tg_ctrl), 32'b100);
        chk("start_y", 32'(y_out), 32'hA5);
        chk("start_cur", 32'(cur_sel), 32'd2);

        sel = 2'd0; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        chk("guard1_tg", 32'(tg_ctrl), 32'd0);
        chk("guard1_busy", 32'(busy), 32'd1);
        chk("guard1_ready", 32'(sel_ready), 32'd0);
        step();
        chk("guard2_tg", 32'(tg_ctrl), 32'd0);
        chk("guard2_busy", 32'(busy), 32'd1);
        step();
        chk("switch_tg", 32'(tg_ctrl), 32'b001);
        chk("switch_y", 32'(y_out), 32'h3C);
        chk("switch_busy", 32'(busy), 32'd0);
        chk("switch_ready", 32'(sel_ready), 32'd1);
        din[7:0] = 8'hC3;
        #1;
        chk("comb_y", 32'(y_out), 32'hC3);

        sel = 2'd3; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        chk("bad_err", 32'(sel_err), 32'd1);
        chk("bad_tg", 32'(tg_ctrl), 32'b001);
        step();
        chk("bad_err_pulse", 32'(sel_err), 32'd0);

        sel = 2'd1; sel_valid = 1'b1;
        step();
        sel_valid = 1'b0;
        chk("abort_in_guard", 32'(busy), 32'd1);
        en = 1'b0;
        step();
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_tg", 32'(tg_ctrl), 32'd0);
        chk("abort_ready", 32'(sel_ready), 32'd1);
        en = 1'b1;
        step();
        step();
        chk("reenable_tg", 32'(tg_ctrl), 32'd0);

        for (int c = 0; c < 2000; c++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            en        = ($urandom_range(0, 7) != 0);
            sel_valid = ($urandom_range(0, 2) == 0);
            sel       = SELW'($urandom_range(0, 3));
            din       = NCH*WIDTH'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
